// File: rtl/ethernet_pkg.sv
// rtl/ethernet_pkg.sv - Ethernet stream beat format and ethertype constants
package ethernet_pkg;

  typedef struct packed {
    logic [7:0]  tkeep;
    logic [63:0] tdata;
    logic        tlast;
    logic        tuser;
  } beat_t;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;

endpackage

// File: rtl/ip_pkg.sv
// rtl/ip_pkg.sv - IPv4 header constants used by the receive classifier
package ip_pkg;

  localparam logic [7:0] IP_PROTO_UDP  = 8'd17;
  localparam logic [7:0] IP_VER_IHL5   = 8'h45;

endpackage

// File: rtl/eth_rxdemux.sv
// rtl/eth_rxdemux.sv - steers received frames to one of two output FIFOs by UDP destination port
module eth_rxdemux
  import ethernet_pkg::*;
  import ip_pkg::*;
#(
  parameter logic [15:0] UDP_PORT  = 16'h3000,
  parameter int          CHECK_IHL = 1
) (
  input  logic        clk156,
  input  logic        sys_rst,
  output logic        in_rd_en,
  input  logic [73:0] in_dout,
  input  logic        in_empty,
  output logic        fifo0_wr_en,
  output logic [73:0] fifo0_din,
  input  logic        fifo0_full,
  output logic        fifo1_wr_en,
  output logic [73:0] fifo1_din,
  input  logic        fifo1_full,
  output logic [31:0] frm_cnt0,
  output logic [31:0] frm_cnt1
);

  typedef enum logic [1:0] {S_HDR, S_FLUSH, S_PASS} state_t;

  state_t     state, state_nxt;
  logic [2:0] hcnt;
  logic [2:0] fcnt;
  logic [2:0] nlast;
  logic       sel;
  beat_t      hbuf [0:4];

  beat_t      in_beat;
  beat_t      out_beat;
  logic       wr_en;
  logic       sel_full;
  logic       hdr_done;
  logic       hdr_match;

  logic [15:0] eth_type;
  logic [7:0]  ver_ihl;
  logic [7:0]  ip_proto;
  logic [15:0] udp_dport;

  assign in_beat  = beat_t'(in_dout);
  assign sel_full = sel ? fifo1_full : fifo0_full;
  assign hdr_done = (hcnt == 3'd4) || in_beat.tlast;

  // Header bytes: 12-14 live in beat 1, 23 in beat 2, 36-37 in beat 4 (the beat being popped)
  assign eth_type  = {hbuf[1].tdata[39:32], hbuf[1].tdata[47:40]};
  assign ver_ihl   = hbuf[1].tdata[55:48];
  assign ip_proto  = hbuf[2].tdata[63:56];
  assign udp_dport = {in_beat.tdata[39:32], in_beat.tdata[47:40]};

  assign hdr_match = (hcnt == 3'd4) &&
                     (eth_type == ETH_TYPE_IPV4) &&
                     (ip_proto == IP_PROTO_UDP) &&
                     ((CHECK_IHL == 0) || (ver_ihl == IP_VER_IHL5)) &&
                     (udp_dport == UDP_PORT);

  always_comb begin
    state_nxt = state;
    in_rd_en  = 1'b0;
    wr_en     = 1'b0;
    out_beat  = in_beat;
    if (!sys_rst) begin
      case (state)
        S_HDR: begin
          in_rd_en = !in_empty;
          if (in_rd_en && hdr_done) state_nxt = S_FLUSH;
        end
        S_FLUSH: begin
          out_beat = hbuf[fcnt];
          wr_en    = !sel_full;
          if (wr_en && (fcnt == nlast)) state_nxt = hbuf[fcnt].tlast ? S_HDR : S_PASS;
        end
        S_PASS: begin
          in_rd_en = !in_empty && !sel_full;
          wr_en    = in_rd_en;
          if (in_rd_en && in_beat.tlast) state_nxt = S_HDR;
        end
        default: state_nxt = S_HDR;
      endcase
    end
  end

  assign fifo0_wr_en = wr_en && !sel;
  assign fifo1_wr_en = wr_en && sel;
  assign fifo0_din   = out_beat;
  assign fifo1_din   = out_beat;

  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      state    <= S_HDR;
      hcnt     <= 3'd0;
      fcnt     <= 3'd0;
      nlast    <= 3'd0;
      sel      <= 1'b0;
      frm_cnt0 <= 32'd0;
      frm_cnt1 <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == S_HDR && in_rd_en) begin
        if (hdr_done) begin
          hcnt  <= 3'd0;
          nlast <= hcnt;
          sel   <= hdr_match;
        end else begin
          hcnt <= hcnt + 3'd1;
        end
      end
      if (state == S_FLUSH && wr_en) fcnt <= (state_nxt == S_FLUSH) ? fcnt + 3'd1 : 3'd0;
      if (wr_en && out_beat.tlast) begin
        if (sel) frm_cnt1 <= frm_cnt1 + 32'd1;
        else     frm_cnt0 <= frm_cnt0 + 32'd1;
      end
    end
  end

  // Buffer contents need no reset: hcnt alone marks which entries belong to the current frame
  always_ff @(posedge clk156) begin
    if (state == S_HDR && in_rd_en) hbuf[hcnt] <= in_beat;
  end

endmodule

// File: tb/tb_eth_rxdemux.sv
// tb/tb_eth_rxdemux.sv - scoreboard bench for eth_rxdemux with random frames and directed corner cases
module tb_eth_rxdemux;

  logic        clk156 = 1'b0;
  logic        sys_rst;
  logic        in_rd_en;
  logic [73:0] in_dout;
  logic        in_empty;
  logic        fifo0_wr_en, fifo1_wr_en;
  logic [73:0] fifo0_din, fifo1_din;
  logic        fifo0_full, fifo1_full;
  logic [31:0] frm_cnt0, frm_cnt1;

  always #5 clk156 = ~clk156;

  eth_rxdemux #(.UDP_PORT(16'h3000), .CHECK_IHL(1)) dut (
    .clk156     (clk156),
    .sys_rst    (sys_rst),
    .in_rd_en   (in_rd_en),
    .in_dout    (in_dout),
    .in_empty   (in_empty),
    .fifo0_wr_en(fifo0_wr_en),
    .fifo0_din  (fifo0_din),
    .fifo0_full (fifo0_full),
    .fifo1_wr_en(fifo1_wr_en),
    .fifo1_din  (fifo1_din),
    .fifo1_full (fifo1_full),
    .frm_cnt0   (frm_cnt0),
    .frm_cnt1   (frm_cnt1)
  );

  logic [73:0] in_q [$];
  logic [73:0] exp0 [$];
  logic [73:0] exp1 [$];
  logic [31:0] mcnt0 = 32'd0;
  logic [31:0] mcnt1 = 32'd0;
  int          errors = 0;
  int          checks = 0;
  int          pop_cnt = 0;
  bit          rand_full = 1'b0;
  bit          rand_empty = 1'b0;
  bit          f0_set = 1'b0;
  bit          f1_set = 1'b0;
  bit          do_pop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic refresh_in();
    bit hold;
    hold     = rand_empty && ($urandom_range(0, 3) == 0);
    in_empty = (in_q.size() == 0) || hold;
    in_dout  = (in_q.size() != 0) ? in_q[0] : 74'h0;
  endtask

  // Builds a frame from bytes, decides its destination from the header rules, queues expectations
  task automatic send_frame(input int nb, input logic [15:0] et, input logic [7:0] b14,
                            input logic [7:0] pr, input logic [15:0] dp);
    logic [7:0]  fb [];
    logic [63:0] data;
    logic [7:0]  keep;
    logic [73:0] beat;
    bit          to1;
    fb = new[(nb < 5 ? 5 : nb) * 8];
    foreach (fb[i]) fb[i] = 8'($urandom);
    fb[12] = et[15:8]; fb[13] = et[7:0]; fb[14] = b14; fb[23] = pr;
    fb[36] = dp[15:8]; fb[37] = dp[7:0];
    to1 = (nb >= 5) && ({fb[12], fb[13]} == 16'h0800) && (fb[23] == 8'd17) &&
          (fb[14] == 8'h45) && ({fb[36], fb[37]} == 16'h3000);
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 8; k++) data[8*k +: 8] = fb[8*b + k];
      keep = (b == nb - 1) ? 8'($urandom) : 8'hFF;
      beat = {keep, data, (b == nb - 1), 1'($urandom)};
      in_q.push_back(beat);
      if (to1) exp1.push_back(beat);
      else     exp0.push_back(beat);
    end
    if (to1) mcnt1 = mcnt1 + 32'd1;
    else     mcnt0 = mcnt0 + 32'd1;
  endtask

  task automatic wait_pops(input int target, input int budget);
    int n;
    n = 0;
    while (pop_cnt < target && n < budget) begin
      @(posedge clk156); #2;
      n++;
    end
    chk("wait_pops_timeout", (pop_cnt >= target), 1);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((in_q.size() != 0 || exp0.size() != 0 || exp1.size() != 0) && n < budget) begin
      @(posedge clk156); #2;
      n++;
    end
    repeat (3) @(posedge clk156);
    #2;
    chk({name, "_drain_timeout"}, (n < budget), 1);
    chk({name, "_frm_cnt0"}, frm_cnt0, mcnt0);
    chk({name, "_frm_cnt1"}, frm_cnt1, mcnt1);
  endtask

  // Input FIFO and output-full driver: pops decided at the negedge are applied after the posedge
  always begin
    @(negedge clk156);
    do_pop = in_rd_en && !in_empty;
    @(posedge clk156); #1;
    if (do_pop && in_q.size() != 0) begin
      void'(in_q.pop_front());
      pop_cnt++;
    end
    refresh_in();
    if (rand_full) begin
      fifo0_full = ($urandom_range(0, 3) == 0);
      fifo1_full = ($urandom_range(0, 3) == 0);
    end else begin
      fifo0_full = f0_set;
      fifo1_full = f1_set;
    end
  end

  always @(negedge clk156) begin
    if (sys_rst) begin
      chk("rst_in_rd_en", in_rd_en, 0);
      chk("rst_fifo0_wr_en", fifo0_wr_en, 0);
      chk("rst_fifo1_wr_en", fifo1_wr_en, 0);
    end else begin
      if (in_rd_en && in_empty) chk("pop_while_empty", 1, 0);
      if (fifo0_wr_en) begin
        chk("fifo0_wr_while_full", fifo0_full, 0);
        checks++;
        if (exp0.size() == 0) begin
          errors++;
          $display("FAIL fifo0_unexpected act=%h exp=none", fifo0_din);
        end else if (fifo0_din !== exp0[0]) begin
          errors++;
          $display("FAIL fifo0_beat act=%h exp=%h", fifo0_din, exp0[0]);
          void'(exp0.pop_front());
        end else begin
          void'(exp0.pop_front());
        end
      end
      if (fifo1_wr_en) begin
        chk("fifo1_wr_while_full", fifo1_full, 0);
        checks++;
        if (exp1.size() == 0) begin
          errors++;
          $display("FAIL fifo1_unexpected act=%h exp=none", fifo1_din);
        end else if (fifo1_din !== exp1[0]) begin
          errors++;
          $display("FAIL fifo1_beat act=%h exp=%h", fifo1_din, exp1[0]);
          void'(exp1.pop_front());
        end else begin
          void'(exp1.pop_front());
        end
      end
    end
  end

  initial begin
    int base;
    sys_rst    = 1'b1;
    in_empty   = 1'b1;
    in_dout    = 74'h0;
    fifo0_full = 1'b0;
    fifo1_full = 1'b0;
    repeat (3) @(posedge clk156);
    #2 sys_rst = 1'b0;
    chk("reset_frm_cnt0", frm_cnt0, 0);
    chk("reset_frm_cnt1", frm_cnt1, 0);

    // Matching 8-beat UDP frame; first write one cycle after the 5th pop
    base = pop_cnt;
    send_frame(8, 16'h0800, 8'h45, 8'd17, 16'h3000);
    wait_pops(base + 5, 50);
    @(negedge clk156);
    chk("latency_fifo1_wr_en", fifo1_wr_en, 1);
    drain("udp_match", 200);

    send_frame(8, 16'h0800, 8'h45, 8'd17, 16'h3001);
    drain("udp_dport_miss", 200);

    send_frame(3, 16'h0800, 8'h45, 8'd17, 16'h3000);
    send_frame(6, 16'h0800, 8'h45, 8'd17, 16'h3000);
    drain("short_then_match", 200);

    send_frame(7, 16'h0800, 8'h46, 8'd17, 16'h3000);
    send_frame(5, 16'h0800, 8'h45, 8'd6, 16'h3000);
    send_frame(1, 16'h0800, 8'h45, 8'd17, 16'h3000);
    send_frame(5, 16'h0800, 8'h45, 8'd17, 16'h3000);
    drain("field_misses", 300);

    // Stall during flush: fifo1 full for 10 cycles right after the header is buffered
    base = pop_cnt;
    send_frame(9, 16'h0800, 8'h45, 8'd17, 16'h3000);
    send_frame(6, 16'h0800, 8'h45, 8'd17, 16'h3000);
    wait_pops(base + 5, 50);
    f1_set = 1'b1;
    fifo1_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk156);
      chk("stall_in_rd_en", in_rd_en, 0);
      chk("stall_fifo1_wr_en", fifo1_wr_en, 0);
      @(posedge clk156); #2;
    end
    f1_set = 1'b0;
    fifo1_full = 1'b0;
    drain("flush_stall", 300);

    // Reset pulse after beat 6 of a 10-beat frame
    base = pop_cnt;
    send_frame(10, 16'h0800, 8'h45, 8'd17, 16'h3000);
    wait_pops(base + 7, 60);
    sys_rst = 1'b1;
    in_q.delete();
    exp0.delete();
    exp1.delete();
    mcnt0 = 32'd0;
    mcnt1 = 32'd0;
    refresh_in();
    @(posedge clk156); #2;
    sys_rst = 1'b0;
    chk("post_reset_frm_cnt0", frm_cnt0, 0);
    chk("post_reset_frm_cnt1", frm_cnt1, 0);
    send_frame(8, 16'h0800, 8'h45, 8'd17, 16'h3000);
    drain("after_reset", 200);

    // Counter wrap
    @(negedge clk156);
    force dut.frm_cnt0 = 32'hFFFFFFFF;
    @(negedge clk156);
    release dut.frm_cnt0;
    mcnt0 = 32'hFFFFFFFF;
    send_frame(6, 16'h86DD, 8'h45, 8'd17, 16'h3000);
    drain("cnt0_wrap", 200);

    // Random traffic with random input gaps and output back-pressure
    rand_full  = 1'b1;
    rand_empty = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int          kind;
      int          nb;
      logic [15:0] et;
      logic [7:0]  b14, pr;
      logic [15:0] dp;
      kind = $urandom_range(0, 5);
      nb   = $urandom_range(1, 12);
      et = 16'h0800; b14 = 8'h45; pr = 8'd17; dp = 16'h3000;
      case (kind)
        1: et  = 16'h0806;
        2: pr  = 8'd6;
        3: b14 = 8'h46;
        4: dp  = 16'h3000 ^ 16'(1 << $urandom_range(0, 15));
        5: begin et = 16'($urandom); b14 = 8'($urandom); pr = 8'($urandom); dp = 16'($urandom); end
        default: ;
      endcase
      send_frame(nb, et, b14, pr, dp);
    end
    drain("random", 20000);
    rand_full  = 1'b0;
    rand_empty = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
